coherence_request_arbiter: RTL and testbench

- Round-robin arbiter directly upstream of the coherence controller's shared-bus logic.
- Collects per-cache coherence requests and selects one using a masked lowest-set-bit priority encode.
- Issues a registered grant, and holds it until the coherence controller signals transaction completion.
- Ensures only one cache drives a bus transaction at a time and that no requester starves.

---
 rtl/coherence_request_arbiter.sv | 121 ++++++++++++
 tb/tb_coherence_request_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/coherence_request_arbiter.sv
// Round-robin arbiter in front of the coherence controller's shared bus.
// Picks one requesting cache with a masked lowest-set-bit search starting
// just above the last served port, registers the grant, and holds it until
// the controller pulses done. Only one cache ever owns the bus at a time.
module coherence_request_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int INDEX_W   = $clog2(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] request,
  input  logic                 done,
  output logic                 grant_valid,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [INDEX_W-1:0]   grant_index,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic                   grant_valid_reg, grant_valid_next;
  logic [NUM_PORTS-1:0]   grant_onehot_reg, grant_onehot_next;
  logic [INDEX_W-1:0]     grant_index_reg, grant_index_next;
  logic [INDEX_W-1:0]     last_index_reg, last_index_next;

  // Ports at or below the last served index lose priority this round.
  logic [NUM_PORTS-1:0]   low_mask;
  logic [NUM_PORTS-1:0]   masked;
  logic [INDEX_W-1:0]     selected;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
      assign low_mask[gi] = (INDEX_W'(gi) <= last_index_reg);
    end
  endgenerate

  assign masked = request & ~low_mask;

  // Lowest set bit of a request vector; zero when the vector is empty.
  function automatic logic [INDEX_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] vec);
    logic [INDEX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = INDEX_W'(i);
      end
    end
    return idx;
  endfunction

  // Prefer ports above last_index; wrap to the lowest requester otherwise.
  always_comb begin
    selected = '0;
    if (|masked) begin
      selected = lowest_set(masked);
    end else begin
      selected = lowest_set(request);
    end
  end

  // Next-state and next-grant logic for the IDLE/BUSY handshake.
  always_comb begin
    state_next        = state_reg;
    grant_valid_next  = grant_valid_reg;
    grant_onehot_next = grant_onehot_reg;
    grant_index_next  = grant_index_reg;
    last_index_next   = last_index_reg;
    case (state_reg)
      IDLE: begin
        // done is meaningless here; only a pending request starts a grant.
        if (|request) begin
          grant_index_next  = selected;
          grant_onehot_next = NUM_PORTS'(1) << selected;
          grant_valid_next  = 1'b1;
          state_next        = BUSY;
        end
      end
      BUSY: begin
        // Grant is held regardless of request; only done releases the bus.
        if (done) begin
          grant_valid_next  = 1'b0;
          grant_onehot_next = '0;
          last_index_next   = grant_index_reg;
          state_next        = IDLE;
        end
      end
      default: begin
        state_next        = IDLE;
        grant_valid_next  = 1'b0;
        grant_onehot_next = '0;
      end
    endcase
  end

  // State and grant registers; reset drops any grant immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      grant_valid_reg  <= 1'b0;
      grant_onehot_reg <= '0;
      grant_index_reg  <= '0;
      last_index_reg   <= INDEX_W'(NUM_PORTS - 1);
    end else begin
      state_reg        <= state_next;
      grant_valid_reg  <= grant_valid_next;
      grant_onehot_reg <= grant_onehot_next;
      grant_index_reg  <= grant_index_next;
      last_index_reg   <= last_index_next;
    end
  end

  assign grant_valid  = grant_valid_reg;
  assign grant_onehot = grant_onehot_reg;
  assign grant_index  = grant_index_reg;
  assign busy         = (state_reg == BUSY);

endmodule

// File: tb/tb_coherence_request_arbiter.sv
// Directed bench for coherence_request_arbiter (NUM_PORTS=4): a cycle-by-cycle
// vector table plus a hand-written round-robin rotation sequence.
module tb_coherence_request_arbiter;

  localparam int NUM_PORTS = 4;
  localparam int INDEX_W   = 2;
  localparam int NUM_VECS  = 28;

  logic                 clock;
  logic                 reset;
  logic [NUM_PORTS-1:0] request;
  logic                 done;
  logic                 grant_valid;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic [INDEX_W-1:0]   grant_index;
  logic                 busy;

  int checks_total;
  int checks_passed;

  coherence_request_arbiter #(.NUM_PORTS(NUM_PORTS)) dut (
    .clock        (clock),
    .reset        (reset),
    .request      (request),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic                 rst;
    logic [NUM_PORTS-1:0] req;
    logic                 dn;
    logic                 exp_valid;
    logic [INDEX_W-1:0]   exp_index;
    logic [NUM_PORTS-1:0] exp_onehot;
  } vec_t;

  vec_t vecs [NUM_VECS];

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compare {valid, busy, onehot, index} against the expected grant.
  task automatic check(input string name, input logic ev, input logic [INDEX_W-1:0] ei,
                       input logic [NUM_PORTS-1:0] eo);
    logic [7:0] act;
    logic [7:0] exp;
    act = {grant_valid, busy, grant_onehot, grant_index};
    exp = {ev, ev, eo, ei};
    checks_total++;
    if (act === exp) begin
      checks_passed++;
      $display("ok   %s: valid=%b busy=%b onehot=%b index=%0d", name,
               grant_valid, busy, grant_onehot, grant_index);
    end else begin
      $display("FAIL %s: got valid=%b busy=%b onehot=%b index=%0d, want valid=%b busy=%b onehot=%b index=%0d",
               name, grant_valid, busy, grant_onehot, grant_index, ev, ev, eo, ei);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset   = 1'b1;
    request = '0;
    done    = 1'b0;

    //                rst   req      done  valid idx   onehot
    // Reset, then idle with no requests.
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    // 1010 after reset -> port 1; held while request changes/withdraws.
    vecs[6]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[7]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010};
    // done drops grant, index holds; last=1 so port 3 next.
    vecs[9]  = '{1'b0, 4'b1000, 1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[10] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000};
    // last=3: port 3 again via wrap; reset mid-BUSY with no done.
    vecs[12] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[13] = '{1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[14] = '{1'b0, 4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    // done while IDLE is ignored.
    vecs[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    // Serve port 2 (last=0), then 0101 wraps to 0; then 0101 from last=0 -> 2.
    vecs[18] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[19] = '{1'b0, 4'b0101, 1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[20] = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[21] = '{1'b0, 4'b0101, 1'b1, 1'b0, 2'd0, 4'b0000};
    vecs[22] = '{1'b0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[23] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    // Port 1 busy; done and 0100 together -> drop, then port 2.
    vecs[24] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[25] = '{1'b0, 4'b0100, 1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[26] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[27] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};

    for (int v = 0; v < NUM_VECS; v++) begin
      reset   = vecs[v].rst;
      request = vecs[v].req;
      done    = vecs[v].dn;
      step();
      check($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_index, vecs[v].exp_onehot);
    end

    // Rotation: all ports requesting, done two cycles after each grant.
    reset   = 1'b1;
    request = 4'b0000;
    done    = 1'b0;
    step();
    check("rot_reset", 1'b0, 2'd0, 4'b0000);
    reset   = 1'b0;
    request = 4'b1111;
    step();
    check("rot_grant0", 1'b1, 2'd0, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      logic [INDEX_W-1:0]   cur;
      logic [INDEX_W-1:0]   nxt;
      logic [NUM_PORTS-1:0] cur_oh;
      logic [NUM_PORTS-1:0] nxt_oh;
      cur    = INDEX_W'(k % NUM_PORTS);
      nxt    = INDEX_W'((k + 1) % NUM_PORTS);
      cur_oh = NUM_PORTS'(1) << cur;
      nxt_oh = NUM_PORTS'(1) << nxt;
      step();
      check($sformatf("rot_hold%0d", k), 1'b1, cur, cur_oh);
      done = 1'b1;
      step();
      check($sformatf("rot_gap%0d", k), 1'b0, cur, 4'b0000);
      done = 1'b0;
      step();
      check($sformatf("rot_grant%0d", k + 1), 1'b1, nxt, nxt_oh);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
